cavlc_block_sequencer: RTL and testbench
========================================

# cavlc_block_sequencer

Top-level per-block controller for the CAVLC decoder. It runs the four syntax phases for one residual block in order: coeff_token, levels, total_zeros and run_before. It drives each sub-decoder's Enable, latches the block parameters passed between phases, and muxes the active sub-decoder's NumShift/ShiftEn onto the shared bitstream shifter. It also skips phases the block syntax makes empty, and it flags malformed or hung blocks.

## Interface
- MAX_COEFF, 16, largest legal MaxNumCoeff; sets width checks.
- TIMEOUT, 255, maximum cycles any single phase may hold Enable before Error.

Ports:
- Clk  in  1  clock
- Reset  in  1  synchronous, active-high reset
- Start  in  1  begin one block; accepted only in IDLE
- MaxNumCoeff  in  5  16 (luma 4x4), 15 (AC) or 4 (chroma DC); latched on accepted Start
- BitsValid  in  1  shifter holds ≥32 valid bits
- Busy  out  1  block in progress (not IDLE)
- BlockDone  out  1  one-cycle pulse, block decoded
- Error  out  1  one-cycle pulse, block aborted
- BlockCount  out  16  completed blocks, wraps
- CtEnable / LvEnable / TzEnable / RbEnable  out  1  per-phase enables
- CtDone / LvDone / TzDone / RbDone  in  1  per-phase completion
- CtTotalCoeff  in  5; CtTrailingOnes  in  2; TzTotalZeros  in  4  phase results
- Ct/Lv/Tz/RbNumShift  in  5; Ct/Lv/Tz/RbShiftEn  in  1  per-phase shift requests
- TotalCoeff  out  5; TrailingOnes  out  2; TotalZeros  out  4  registered block parameters
- NumShift  out  5; ShiftEn  out  1  muxed shift request to shifter

## Operation
- States: IDLE, COEFF_TOKEN, LEVELS, TOTAL_ZEROS, RUN_BEFORE, DONE, ERROR.
- IDLE + Start → COEFF_TOKEN. Start is ignored in every other state.
- Arming:
  - On entering a phase state, the Armed flag clears.
  - The phase Enable is 0 until the first cycle BitsValid=1. In that cycle Armed sets and Enable=1.
  - Once armed, Enable stays 1 until that phase's Done, regardless of BitsValid.
- Enables are combinational from state & (Armed | BitsValid). At most one Enable is high at any time.
- NumShift/ShiftEn come from the active phase's inputs when its Enable=1. Otherwise both are 0.
- A phase's Done is sampled only while its Enable=1. The transition occurs on that edge, so Enable drops the following cycle.
- Transitions:
  - COEFF_TOKEN done:
    - Latch TotalCoeff and TrailingOnes.
    - If CtTotalCoeff > MaxNumCoeff, or CtTrailingOnes > min(3, CtTotalCoeff) → ERROR.
    - Else if CtTotalCoeff==0 → DONE, with TotalZeros=0.
    - Else → LEVELS.
  - LEVELS done:
    - If TotalCoeff==MaxNumCoeff → DONE, with TotalZeros=0.
    - Else → TOTAL_ZEROS.
  - TOTAL_ZEROS done:
    - Latch TotalZeros.
    - If TzTotalZeros > MaxNumCoeff−TotalCoeff → ERROR.
    - Else if TzTotalZeros==0 or TotalCoeff==1 → DONE.
    - Else → RUN_BEFORE.
  - RUN_BEFORE done → DONE.
  - DONE: BlockDone=1, BlockCount+1 (mod 2^16), → IDLE.
  - ERROR: Error=1, → IDLE. BlockCount does not increment.
- Watchdog:
  - Counter clears on every state change.
  - It increments each cycle a phase Enable=1.
  - Reaching TIMEOUT while still in the phase → ERROR.
- TotalCoeff/TrailingOnes/TotalZeros hold their values until the next accepted Start, which clears them to 0.

## Timing
- Reset:
  - state=IDLE; Armed=0; watchdog=0; BlockCount=0.
  - Busy, BlockDone, Error, all Enables, ShiftEn, NumShift, TotalCoeff, TrailingOnes and TotalZeros are 0.
- Reset mid-block: the next cycle is IDLE with all Enables 0. No BlockDone or Error pulse is produced.
- Reset wins over a simultaneous Start.
- Start at edge N → CtEnable=1 at cycle N+1 if BitsValid=1.
- Done at cycle k → the next phase Enable at k+1 if BitsValid=1. No bubble beyond the arming wait.
- Fastest block (TotalCoeff=0, Done in first cycle): Start edge 0, CtEnable cycle 1, BlockDone cycle 2, IDLE cycle 3.
- BlockDone and Error are mutually exclusive and last exactly one cycle each.
- Busy=1 from the cycle after Start through the DONE/ERROR cycle inclusive.
- Done and watchdog expiry in the same cycle: Done wins.

## Structure
- cavlc_pkg holds:
  - the state enum cavlc_seq_state_t;
  - MAX_TRAILING_ONES=3;
  - the phase-select enum used by the shift mux;
  - the shared width localparams (COEFF_W=5, ZEROS_W=4, SHIFT_W=5).
- One sub-module, cavlc_phase_watchdog: counter, clear-on-phase-change, TIMEOUT compare, expiry output.

## Test plan
- MaxNumCoeff=16; CtTotalCoeff=0 with CtDone in first cycle → LEVELS/TZ/RB never enabled; BlockDone at cycle 2; BlockCount=1.
- CtTotalCoeff=5, T1s=2, TzTotalZeros=3 → phases CT, LV, TZ, RB in order; one Enable at a time; NumShift tracks the active phase; TotalZeros=3 at BlockDone.
- CtTotalCoeff=16 with MaxNumCoeff=16 → TOTAL_ZEROS skipped; TotalZeros=0. Separately, CtTotalCoeff=1, TzTotalZeros=4 → RUN_BEFORE skipped.
- BitsValid=0 for 7 cycles on entry to LEVELS → LvEnable stays 0 and the watchdog does not count; then BitsValid=1 → LvEnable=1; a later BitsValid drop does not drop LvEnable.
- LvDone withheld 255 cycles → Error pulse once, IDLE, BlockCount unchanged. CtTotalCoeff=5 with MaxNumCoeff=4 → Error.
- Reset asserted during RUN_BEFORE → next cycle all outputs 0; a subsequent Start decodes normally.

Source files
------------

// File: rtl/cavlc_pkg.sv
// Shared types and widths for the CAVLC per-block sequencer.
// The state and phase enums are also used by the shift mux and debug output.
package cavlc_pkg;

  localparam int COEFF_W = 5;
  localparam int ZEROS_W = 4;
  localparam int SHIFT_W = 5;
  localparam int T1_W    = 2;

  localparam logic [T1_W-1:0] MAX_TRAILING_ONES = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_COEFF_TOKEN = 3'd1,
    S_LEVELS      = 3'd2,
    S_TOTAL_ZEROS = 3'd3,
    S_RUN_BEFORE  = 3'd4,
    S_DONE        = 3'd5,
    S_ERROR       = 3'd6
  } cavlc_seq_state_t;

  typedef enum logic [2:0] {
    PH_NONE = 3'd0,
    PH_CT   = 3'd1,
    PH_LV   = 3'd2,
    PH_TZ   = 3'd3,
    PH_RB   = 3'd4
  } cavlc_phase_t;

  function automatic cavlc_phase_t phase_of(input cavlc_seq_state_t s);
    case (s)
      S_COEFF_TOKEN: return PH_CT;
      S_LEVELS:      return PH_LV;
      S_TOTAL_ZEROS: return PH_TZ;
      S_RUN_BEFORE:  return PH_RB;
      default:       return PH_NONE;
    endcase
  endfunction

  // Trailing ones can never exceed the coefficient count, nor three.
  function automatic logic [T1_W-1:0] max_t1(input logic [COEFF_W-1:0] tc);
    return (tc > COEFF_W'(3)) ? MAX_TRAILING_ONES : tc[T1_W-1:0];
  endfunction

endpackage

// File: rtl/cavlc_phase_watchdog.sv
// Per-phase hang detector: counts cycles a phase holds Enable and flags
// expiry on the cycle the count would reach TIMEOUT.
module cavlc_phase_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_expired;

  assign w_expired = i_count && (r_count == LAST);
  assign o_expired = w_expired;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear || w_expired) begin
      r_count <= '0;
    end else if (i_count) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cavlc_block_sequencer.sv
// Per-block CAVLC controller: steps coeff_token, levels, total_zeros and
// run_before, latches block parameters and muxes shift requests.
module cavlc_block_sequencer
  import cavlc_pkg::*;
#(
  parameter int MAX_COEFF = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [COEFF_W-1:0] i_max_num_coeff,
  input  logic               i_bits_valid,
  output logic               o_busy,
  output logic               o_block_done,
  output logic               o_error,
  output logic [15:0]        o_block_count,
  output logic               o_ct_enable,
  output logic               o_lv_enable,
  output logic               o_tz_enable,
  output logic               o_rb_enable,
  input  logic               i_ct_done,
  input  logic               i_lv_done,
  input  logic               i_tz_done,
  input  logic               i_rb_done,
  input  logic [COEFF_W-1:0] i_ct_total_coeff,
  input  logic [T1_W-1:0]    i_ct_trailing_ones,
  input  logic [ZEROS_W-1:0] i_tz_total_zeros,
  input  logic [SHIFT_W-1:0] i_ct_num_shift,
  input  logic [SHIFT_W-1:0] i_lv_num_shift,
  input  logic [SHIFT_W-1:0] i_tz_num_shift,
  input  logic [SHIFT_W-1:0] i_rb_num_shift,
  input  logic               i_ct_shift_en,
  input  logic               i_lv_shift_en,
  input  logic               i_tz_shift_en,
  input  logic               i_rb_shift_en,
  output logic [COEFF_W-1:0] o_total_coeff,
  output logic [T1_W-1:0]    o_trailing_ones,
  output logic [ZEROS_W-1:0] o_total_zeros,
  output logic [SHIFT_W-1:0] o_num_shift,
  output logic               o_shift_en,
  output logic [2:0]         o_dbg_state
);

  cavlc_seq_state_t   r_state;
  logic               r_armed;
  logic               r_busy;
  logic               r_block_done;
  logic               r_error;
  logic [15:0]        r_block_count;
  logic [COEFF_W-1:0] r_max;
  logic [COEFF_W-1:0] r_total_coeff;
  logic [T1_W-1:0]    r_trailing_ones;
  logic [ZEROS_W-1:0] r_total_zeros;

  cavlc_phase_t       w_phase;
  logic               w_phase_enable;
  logic               w_active_done;
  logic               w_expired;
  logic               w_ct_bad;
  logic               w_tz_bad;
  logic [COEFF_W-1:0] w_zeros_room;
  logic [SHIFT_W-1:0] w_num_shift;
  logic               w_shift_en;

  // Enable waits for the first BitsValid of a phase, then holds until Done.
  assign w_phase        = phase_of(r_state);
  assign w_phase_enable = (w_phase != PH_NONE) && (r_armed || i_bits_valid);

  assign o_ct_enable = w_phase_enable && (w_phase == PH_CT);
  assign o_lv_enable = w_phase_enable && (w_phase == PH_LV);
  assign o_tz_enable = w_phase_enable && (w_phase == PH_TZ);
  assign o_rb_enable = w_phase_enable && (w_phase == PH_RB);

  assign w_active_done = (o_ct_enable && i_ct_done) || (o_lv_enable && i_lv_done) ||
                         (o_tz_enable && i_tz_done) || (o_rb_enable && i_rb_done);

  assign w_ct_bad = (i_ct_total_coeff > r_max) ||
                    (i_ct_total_coeff > COEFF_W'(MAX_COEFF)) ||
                    (i_ct_trailing_ones > max_t1(i_ct_total_coeff));

  assign w_zeros_room = r_max - r_total_coeff;
  assign w_tz_bad     = {1'b0, i_tz_total_zeros} > w_zeros_room;

  cavlc_phase_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   ((w_phase == PH_NONE) || w_active_done),
    .i_count   (w_phase_enable),
    .o_expired (w_expired)
  );

  always_comb begin
    w_num_shift = '0;
    w_shift_en  = 1'b0;
    case (w_phase)
      PH_CT: begin w_num_shift = i_ct_num_shift; w_shift_en = i_ct_shift_en; end
      PH_LV: begin w_num_shift = i_lv_num_shift; w_shift_en = i_lv_shift_en; end
      PH_TZ: begin w_num_shift = i_tz_num_shift; w_shift_en = i_tz_shift_en; end
      PH_RB: begin w_num_shift = i_rb_num_shift; w_shift_en = i_rb_shift_en; end
      default: ;
    endcase
    if (!w_phase_enable) begin
      w_num_shift = '0;
      w_shift_en  = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state         <= S_IDLE;
      r_armed         <= 1'b0;
      r_busy          <= 1'b0;
      r_block_done    <= 1'b0;
      r_error         <= 1'b0;
      r_block_count   <= '0;
      r_max           <= '0;
      r_total_coeff   <= '0;
      r_trailing_ones <= '0;
      r_total_zeros   <= '0;
    end else begin
      r_block_done <= 1'b0;
      r_error      <= 1'b0;

      // Done beats a same-cycle watchdog expiry.
      if (w_phase != PH_NONE) begin
        if (w_active_done) begin
          r_armed <= 1'b0;
        end else if (w_expired) begin
          r_state <= S_ERROR;
          r_error <= 1'b1;
          r_armed <= 1'b0;
        end else if (i_bits_valid) begin
          r_armed <= 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state         <= S_COEFF_TOKEN;
            r_armed         <= 1'b0;
            r_busy          <= 1'b1;
            r_max           <= i_max_num_coeff;
            r_total_coeff   <= '0;
            r_trailing_ones <= '0;
            r_total_zeros   <= '0;
          end
        end
        S_COEFF_TOKEN: begin
          if (o_ct_enable && i_ct_done) begin
            r_total_coeff   <= i_ct_total_coeff;
            r_trailing_ones <= i_ct_trailing_ones;
            if (w_ct_bad) begin
              r_state <= S_ERROR;
              r_error <= 1'b1;
            end else if (i_ct_total_coeff == '0) begin
              r_state       <= S_DONE;
              r_block_done  <= 1'b1;
              r_total_zeros <= '0;
            end else begin
              r_state <= S_LEVELS;
            end
          end
        end
        S_LEVELS: begin
          if (o_lv_enable && i_lv_done) begin
            if (r_total_coeff == r_max) begin
              r_state       <= S_DONE;
              r_block_done  <= 1'b1;
              r_total_zeros <= '0;
            end else begin
              r_state <= S_TOTAL_ZEROS;
            end
          end
        end
        S_TOTAL_ZEROS: begin
          if (o_tz_enable && i_tz_done) begin
            r_total_zeros <= i_tz_total_zeros;
            if (w_tz_bad) begin
              r_state <= S_ERROR;
              r_error <= 1'b1;
            end else if ((i_tz_total_zeros == '0) || (r_total_coeff == COEFF_W'(1))) begin
              r_state      <= S_DONE;
              r_block_done <= 1'b1;
            end else begin
              r_state <= S_RUN_BEFORE;
            end
          end
        end
        S_RUN_BEFORE: begin
          if (o_rb_enable && i_rb_done) begin
            r_state      <= S_DONE;
            r_block_done <= 1'b1;
          end
        end
        S_DONE: begin
          r_state       <= S_IDLE;
          r_busy        <= 1'b0;
          r_block_count <= r_block_count + 16'd1;
        end
        S_ERROR: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy          = r_busy;
  assign o_block_done    = r_block_done;
  assign o_error         = r_error;
  assign o_block_count   = r_block_count;
  assign o_total_coeff   = r_total_coeff;
  assign o_trailing_ones = r_trailing_ones;
  assign o_total_zeros   = r_total_zeros;
  assign o_num_shift     = w_num_shift;
  assign o_shift_en      = w_shift_en;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_cavlc_block_sequencer.sv
// Directed bench for cavlc_block_sequencer: a responder plays the four
// sub-decoders and each block outcome is scoreboarded against a spec model.
module tb_cavlc_block_sequencer;

  localparam int W = 25;  // {kind[2], tc[5], t1[2], tz[4], phase sequence[12]}
  localparam logic [4:0] NS_CT = 5'd3;
  localparam logic [4:0] NS_LV = 5'd7;
  localparam logic [4:0] NS_TZ = 5'd11;
  localparam logic [4:0] NS_RB = 5'd19;

  logic        clk = 1'b0;
  logic        reset, start, bv;
  logic [4:0]  max_nc;
  logic        ct_done, lv_done, tz_done, rb_done;
  logic        busy, block_done, error;
  logic [15:0] block_count;
  logic        ct_en, lv_en, tz_en, rb_en;
  logic [4:0]  total_coeff, num_shift;
  logic [1:0]  trailing_ones;
  logic [3:0]  total_zeros;
  logic        shift_en;
  logic [2:0]  dbg_state;

  logic [4:0]  g_tc;
  logic [1:0]  g_t1;
  logic [3:0]  g_tz;
  int          g_lat[4];
  int          g_gap_lv;
  bit          g_rand_bv, g_hold_start, g_abort_rb;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          exp_count = 0;
  logic [W-1:0] exp_q[$];
  int          rc, lc;

  always #5 clk = ~clk;

  cavlc_block_sequencer dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_max_num_coeff(max_nc),
    .i_bits_valid(bv), .o_busy(busy), .o_block_done(block_done), .o_error(error),
    .o_block_count(block_count),
    .o_ct_enable(ct_en), .o_lv_enable(lv_en), .o_tz_enable(tz_en), .o_rb_enable(rb_en),
    .i_ct_done(ct_done), .i_lv_done(lv_done), .i_tz_done(tz_done), .i_rb_done(rb_done),
    .i_ct_total_coeff(g_tc), .i_ct_trailing_ones(g_t1), .i_tz_total_zeros(g_tz),
    .i_ct_num_shift(NS_CT), .i_lv_num_shift(NS_LV), .i_tz_num_shift(NS_TZ),
    .i_rb_num_shift(NS_RB),
    .i_ct_shift_en(1'b1), .i_lv_shift_en(1'b1), .i_tz_shift_en(1'b1), .i_rb_shift_en(1'b1),
    .o_total_coeff(total_coeff), .o_trailing_ones(trailing_ones), .o_total_zeros(total_zeros),
    .o_num_shift(num_shift), .o_shift_en(shift_en), .o_dbg_state(dbg_state)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Expected outcome straight from the block syntax rules; kind 1=done, 2=error.
  function automatic logic [W-1:0] model(input logic [4:0] mx, input logic [4:0] tc,
                                         input logic [1:0] t1, input logic [3:0] tz,
                                         input bit lv_hang);
    logic [1:0]  kind;
    logic [1:0]  mt1;
    logic [3:0]  tzo;
    logic [11:0] seq;
    mt1  = (tc >= 5'd3) ? 2'd3 : tc[1:0];
    kind = 2'd1;
    tzo  = 4'd0;
    seq  = 12'd1;
    if (tc > mx || t1 > mt1) begin
      kind = 2'd2;
    end else if (tc != 5'd0) begin
      seq[5:3] = 3'd2;
      if (lv_hang) begin
        kind = 2'd2;
      end else if (tc != mx) begin
        seq[8:6] = 3'd3;
        tzo = tz;
        if ({1'b0, tz} > (mx - tc)) kind = 2'd2;
        else if (tz != 4'd0 && tc != 5'd1) seq[11:9] = 3'd4;
      end
    end
    return {kind, tc, t1, tzo, seq};
  endfunction

  task automatic push_exp(input bit lv_hang);
    logic [W-1:0] e;
    e = model(max_nc, g_tc, g_t1, g_tz, lv_hang);
    exp_q.push_back(e);
    if (e[W-1 -: 2] == 2'd1) exp_count++;
  endtask

  // Start one block, answer enables as the sub-decoders would, and score the outcome.
  task automatic run_block(input int max_wait, output int res_cyc, output int last_cnt);
    logic [3:0]  en, prev_en, prev_done, dn;
    logic [4:0]  exp_ns;
    logic [11:0] seq;
    logic [W-1:0] got, want;
    int nseq, ph, last_ph, ph_cnt, gap;
    int e_hot, e_shift, e_hold, e_gap, e_busy;
    bit first_after_gap, arm_chk, seen, aborted;
    seq = '0; nseq = 0; last_ph = -1; ph_cnt = 0; gap = 0;
    e_hot = 0; e_shift = 0; e_hold = 0; e_gap = 0; e_busy = 0;
    prev_en = '0; prev_done = '0; first_after_gap = 0; seen = 0; aborted = 0;
    res_cyc = -1;
    start = 1'b1;
    cyc();
    for (int c = 1; c <= max_wait; c++) begin
      start = g_hold_start;
      {rb_done, tz_done, lv_done, ct_done} = 4'b0;
      arm_chk = 0;
      if (gap > 0) bv = 1'b0;
      else if (first_after_gap) begin bv = 1'b1; first_after_gap = 0; arm_chk = 1; end
      else if (g_rand_bv) bv = 1'($urandom_range(0, 1));
      else bv = 1'b1;
      #1;
      en = {rb_en, tz_en, lv_en, ct_en};
      if (!busy) e_busy++;
      if (block_done || error) begin res_cyc = c; seen = 1; break; end
      if (g_abort_rb && en[3]) begin reset = 1'b1; start = 1'b1; seen = 1; aborted = 1; break; end
      if (arm_chk && en != 4'b0010) e_gap++;
      if (gap > 0) begin
        if (en != 4'b0) e_gap++;
        gap--;
        if (gap == 0) first_after_gap = 1;
      end
      if ($countones(en) > 1) e_hot++;
      if ((prev_en & ~prev_done & ~en) != 4'b0) e_hold++;
      exp_ns = en[0] ? NS_CT : en[1] ? NS_LV : en[2] ? NS_TZ : en[3] ? NS_RB : 5'd0;
      if (num_shift !== exp_ns || shift_en !== (en != 4'b0)) e_shift++;
      dn = '0;
      if (en != 4'b0) begin
        ph = en[0] ? 0 : en[1] ? 1 : en[2] ? 2 : 3;
        if (ph != last_ph) begin
          if (nseq < 4) seq[3*nseq +: 3] = 3'(ph + 1);
          nseq++;
          last_ph = ph;
          ph_cnt = 0;
        end
        if (g_lat[ph] == ph_cnt) dn[ph] = 1'b1;
        ph_cnt++;
        if (ph == 0 && dn[0] && g_gap_lv > 0) gap = g_gap_lv;
      end
      {rb_done, tz_done, lv_done, ct_done} = dn;
      prev_en = en;
      prev_done = dn;
      cyc();
    end
    {rb_done, tz_done, lv_done, ct_done} = 4'b0;
    if (!g_abort_rb) start = 1'b0;
    last_cnt = ph_cnt;
    check("result_seen", 32'(seen), 32'd1);
    check("busy_in_block", e_busy, 0);
    check("one_hot_enable", e_hot, 0);
    check("enable_holds", e_hold, 0);
    check("shift_mux", e_shift, 0);
    check("arming_gap", e_gap, 0);
    if (seen && !aborted) begin
      got = {error, block_done, total_coeff, trailing_ones, total_zeros, seq};
      want = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      check("block_outcome", 32'(got), 32'(want));
      cyc();
      check("post_idle", {29'd0, busy, block_done, error}, 32'd0);
      check("block_count", 32'(block_count), 32'(exp_count));
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; bv = 1'b1; max_nc = 5'd16;
    {rb_done, tz_done, lv_done, ct_done} = 4'b0;
    g_tc = '0; g_t1 = '0; g_tz = '0; g_lat = '{0, 0, 0, 0};
    g_gap_lv = 0; g_rand_bv = 0; g_hold_start = 0; g_abort_rb = 0;
    repeat (3) cyc();
    check("reset_outputs", {7'd0, busy, block_done, error, ct_en, lv_en, tz_en, rb_en,
                            shift_en, num_shift, total_coeff, trailing_ones, total_zeros},
          32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    check("reset_count", 32'(block_count), 32'd0);
    reset = 1'b0;
    cyc();

    // Empty block: only coeff_token runs, BlockDone two cycles after Start.
    g_tc = 5'd0; push_exp(0);
    run_block(50, rc, lc);
    check("fastest_done_cycle", rc, 2);

    // Full four-phase block with Start held high throughout.
    g_tc = 5'd5; g_t1 = 2'd2; g_tz = 4'd3; g_lat = '{2, 3, 1, 2}; g_hold_start = 1;
    push_exp(0);
    run_block(100, rc, lc);
    g_hold_start = 0;

    // TotalCoeff == MaxNumCoeff skips total_zeros.
    g_tc = 5'd16; g_t1 = 2'd3; g_tz = 4'd5; g_lat = '{1, 0, 0, 0};
    push_exp(0);
    run_block(100, rc, lc);

    // Single coefficient skips run_before.
    g_tc = 5'd1; g_t1 = 2'd1; g_tz = 4'd4;
    push_exp(0);
    run_block(100, rc, lc);

    // BitsValid gap entering levels, then random BitsValid; long but legal levels phase.
    g_tc = 5'd5; g_t1 = 2'd1; g_tz = 4'd2; g_lat = '{0, 253, 2, 1};
    g_gap_lv = 7; g_rand_bv = 1;
    push_exp(0);
    run_block(900, rc, lc);
    g_gap_lv = 0; g_rand_bv = 0;

    // Levels hangs: watchdog aborts after exactly TIMEOUT enabled cycles.
    g_tc = 5'd5; g_t1 = 2'd0; g_tz = 4'd0; g_lat = '{0, -1, 0, 0};
    push_exp(1);
    run_block(600, rc, lc);
    check("watchdog_cycles", lc, 255);

    // Malformed coeff_token results.
    max_nc = 5'd4; g_tc = 5'd5; g_t1 = 2'd0; g_lat = '{0, 0, 0, 0};
    push_exp(0);
    run_block(50, rc, lc);
    max_nc = 5'd16; g_tc = 5'd2; g_t1 = 2'd3;
    push_exp(0);
    run_block(50, rc, lc);

    // TotalZeros one beyond the room left, then exactly at the limit.
    max_nc = 5'd15; g_tc = 5'd10; g_t1 = 2'd3; g_tz = 4'd6;
    push_exp(0);
    run_block(80, rc, lc);
    g_tz = 4'd5;
    push_exp(0);
    run_block(80, rc, lc);

    // Reset (with a simultaneous Start) during run_before.
    max_nc = 5'd16; g_tc = 5'd5; g_t1 = 2'd2; g_tz = 4'd3; g_lat = '{0, 0, 0, -1};
    g_abort_rb = 1;
    run_block(80, rc, lc);
    g_abort_rb = 0;
    cyc();
    reset = 1'b0; start = 1'b0;
    check("abort_outputs", {7'd0, busy, block_done, error, ct_en, lv_en, tz_en, rb_en,
                            shift_en, num_shift, total_coeff, trailing_ones, total_zeros},
          32'd0);
    check("abort_count", 32'(block_count), 32'd0);
    exp_count = 0;
    g_lat = '{1, 1, 1, 1};
    push_exp(0);
    run_block(100, rc, lc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
